mux_transiciones_seq: RTL

//  Parametrised N-channel, W-bit registered selector for screen/scene transitions.

---
 rtl/mux_transiciones_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mux_transiciones_seq.sv
// Registered N-channel selector that blanks its output for a fixed number of cycles on every channel switch.
// Optional one-deep request queue during blanking: define MUXTRANS_PENDING_EN.
module mux_transiciones_seq #(
  parameter int MUXTRANS_SELECTWIDTH = 3,
  parameter int MUXTRANS_CHANNELS    = 8,
  parameter int MUXTRANS_DATAWIDTH   = 4,
  parameter int MUXTRANS_BLANKCYCLES = 4,
  parameter logic [MUXTRANS_DATAWIDTH-1:0] MUXTRANS_BLANKVALUE = '0
) (
  input  logic                                          CC_MUXTRANS_CLOCK_50,
  input  logic                                          CC_MUXTRANS_RESET_InLow,
  input  logic [MUXTRANS_SELECTWIDTH-1:0]               CC_MUXTRANS_select_InBUS,
  input  logic                                          CC_MUXTRANS_req_In,
  input  logic [MUXTRANS_CHANNELS*MUXTRANS_DATAWIDTH-1:0] CC_MUXTRANS_data_InBUS,
  output logic [MUXTRANS_DATAWIDTH-1:0]                 CC_MUXTRANS_z_OutBUS,
  output logic [MUXTRANS_SELECTWIDTH-1:0]               CC_MUXTRANS_active_OutBUS,
  output logic                                          CC_MUXTRANS_busy_Out,
  output logic                                          CC_MUXTRANS_done_Out
);
  localparam int SELW = MUXTRANS_SELECTWIDTH;
  localparam int DW   = MUXTRANS_DATAWIDTH;
  localparam int CNTW = (MUXTRANS_BLANKCYCLES > 1) ? $clog2(MUXTRANS_BLANKCYCLES) : 1;
  localparam logic [CNTW-1:0] RELOAD = CNTW'(MUXTRANS_BLANKCYCLES - 1);

  typedef enum logic {IDLE, BLANK} state_t;

  state_t          state, stateNext;
  logic [SELW-1:0] active, activeNext, target, targetNext, selClamp;
  logic [CNTW-1:0] counter, counterNext;
  logic [DW-1:0]   z, zNext;
  logic            busy, busyNext, done, doneNext;
`ifdef MUXTRANS_PENDING_EN
  logic [SELW-1:0] pend, pendNext;
  logic            pendValid, pendValidNext;
`endif

  function automatic logic [DW-1:0] chan(input logic [SELW-1:0] ch);
    return CC_MUXTRANS_data_InBUS[int'(ch)*DW +: DW];
  endfunction

  always_comb begin
    selClamp = CC_MUXTRANS_select_InBUS;
    if (int'(CC_MUXTRANS_select_InBUS) >= MUXTRANS_CHANNELS)
      selClamp = SELW'(MUXTRANS_CHANNELS - 1);
  end

  always_comb begin
    stateNext   = state;
    activeNext  = active;
    targetNext  = target;
    counterNext = counter;
    zNext       = z;
    busyNext    = busy;
    doneNext    = 1'b0;
`ifdef MUXTRANS_PENDING_EN
    pendNext      = pend;
    pendValidNext = pendValid;
`endif
    case (state)
      IDLE: begin
        zNext = chan(active);
        if (CC_MUXTRANS_req_In && selClamp != active) begin
          targetNext  = selClamp;
          counterNext = RELOAD;
          zNext       = MUXTRANS_BLANKVALUE;
          busyNext    = 1'b1;
          stateNext   = BLANK;
        end
      end
      BLANK: begin
`ifdef MUXTRANS_PENDING_EN
        // A request on the commit edge itself also counts as pending (last wins).
        if (CC_MUXTRANS_req_In) begin
          pendNext      = selClamp;
          pendValidNext = 1'b1;
        end
`endif
        if (counter != '0) begin
          counterNext = counter - 1'b1;
          zNext       = MUXTRANS_BLANKVALUE;
        end else begin
          activeNext = target;
          doneNext   = 1'b1;
`ifdef MUXTRANS_PENDING_EN
          if (pendValidNext && pendNext != target) begin
            counterNext = RELOAD;
            zNext       = MUXTRANS_BLANKVALUE;
            targetNext  = pendNext;
          end else begin
            zNext     = chan(target);
            busyNext  = 1'b0;
            stateNext = IDLE;
          end
          pendValidNext = 1'b0;
`else
          zNext     = chan(target);
          busyNext  = 1'b0;
          stateNext = IDLE;
`endif
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CC_MUXTRANS_CLOCK_50 or negedge CC_MUXTRANS_RESET_InLow) begin
    if (!CC_MUXTRANS_RESET_InLow) begin
      state   <= IDLE;
      active  <= '0;
      target  <= '0;
      counter <= '0;
      z       <= MUXTRANS_BLANKVALUE;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef MUXTRANS_PENDING_EN
      pend      <= '0;
      pendValid <= 1'b0;
`endif
    end else begin
      state   <= stateNext;
      active  <= activeNext;
      target  <= targetNext;
      counter <= counterNext;
      z       <= zNext;
      busy    <= busyNext;
      done    <= doneNext;
`ifdef MUXTRANS_PENDING_EN
      pend      <= pendNext;
      pendValid <= pendValidNext;
`endif
    end
  end

  assign CC_MUXTRANS_z_OutBUS      = z;
  assign CC_MUXTRANS_active_OutBUS = active;
  assign CC_MUXTRANS_busy_Out      = busy;
  assign CC_MUXTRANS_done_Out      = done;
endmodule
